// File: rtl/tx_async_gearbox_pkg.sv
// Shared widths and read-side state encoding for the transmit gearbox.
package tx_async_gearbox_pkg;

    localparam int BLOCK_W = 66;
    localparam int LANE_W  = 32;
    localparam int OFF_W   = 7;

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef enum logic [0:0] {
        GB_PRIME = ST_PRIME,
        GB_RUN   = ST_RUN
    } gearbox_state_t;

endpackage

// File: rtl/tx_async_gearbox_if.sv
// Block-in / lane-out signal bundle of the transmit gearbox.
interface tx_async_gearbox_if;
    import tx_async_gearbox_pkg::*;

    logic [BLOCK_W-1:0] data_in;
    logic               valid_in;
    logic               ready;
    logic               overflow;
    logic [LANE_W-1:0]  data_out;
    logic               valid_out;
    logic               underrun;

    modport master (
        output data_in, valid_in,
        input  ready, overflow, data_out, valid_out, underrun
    );

    modport slave (
        input  data_in, valid_in,
        output ready, overflow, data_out, valid_out, underrun
    );
endinterface

// File: rtl/tx_async_gearbox_gray_ptr_sync.sv
// Pointer crossing: registered bin->Gray in the source domain, reset flop chain
// in the destination domain, Gray->bin at the end.
module tx_async_gearbox_gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             src_clk,
    input  logic             src_rst,
    input  logic [WIDTH-1:0] src_bin,
    input  logic             dst_clk,
    input  logic             dst_rst,
    output logic [WIDTH-1:0] dst_bin
);

    logic [WIDTH-1:0] src_gray;
    logic [WIDTH-1:0] sync_chain [STAGES];

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // source stage: src_bin is the next pointer value, so src_gray tracks the live pointer
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            src_gray <= '0;
        end else begin
            src_gray <= bin2gray(src_bin);
        end
    end

    // destination synchronizer chain
    always_ff @(posedge dst_clk or posedge dst_rst) begin
        if (dst_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_chain[i] <= '0;
            end
        end else begin
            sync_chain[0] <= src_gray;
            for (int i = 1; i < STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
        end
    end

    assign dst_bin = gray2bin(sync_chain[STAGES-1]);

endmodule

// File: rtl/tx_async_gearbox.sv
// 66-bit block to 32-bit lane gearbox: dual-clock block FIFO read at bit
// granularity, with write-side flow control and a prime/run read machine.
module tx_async_gearbox
    import tx_async_gearbox_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PRIME       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_in,
    input  logic                clk_in_reset,
    input  logic                clk_out,
    input  logic                clk_out_reset,
    tx_async_gearbox_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BLOCK_W-1:0] mem [DEPTH];

    logic [CW-1:0] w_cnt, w_cnt_next, w_cnt_sync;
    logic [CW-1:0] r_cnt, r_cnt_next, r_cnt_sync;
    logic [CW-1:0] fill, avail;
    logic          wr_en;
    logic          overflow_p1;

    // write side (clk_in)
    assign fill       = w_cnt - r_cnt_sync;
    assign bus.ready  = !clk_in_reset && (fill < CW'(DEPTH));
    assign wr_en      = bus.valid_in && bus.ready;
    assign w_cnt_next = w_cnt + CW'(wr_en);

    always_ff @(posedge clk_in or posedge clk_in_reset) begin
        if (clk_in_reset) begin
            w_cnt       <= '0;
            overflow_p1 <= 1'b0;
        end else begin
            w_cnt       <= w_cnt_next;
            overflow_p1 <= bus.valid_in && !bus.ready;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[w_cnt[AW-1:0]] <= bus.data_in;
        end
    end

    assign bus.overflow = overflow_p1;

    tx_async_gearbox_gray_ptr_sync #(.WIDTH(CW), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .src_clk (clk_in),
        .src_rst (clk_in_reset),
        .src_bin (w_cnt_next),
        .dst_clk (clk_out),
        .dst_rst (clk_out_reset),
        .dst_bin (w_cnt_sync)
    );

    tx_async_gearbox_gray_ptr_sync #(.WIDTH(CW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .src_clk (clk_out),
        .src_rst (clk_out_reset),
        .src_bin (r_cnt_next),
        .dst_clk (clk_in),
        .dst_rst (clk_in_reset),
        .dst_bin (r_cnt_sync)
    );

    // read side (clk_out): position is entry count plus bit offset 0..65
    gearbox_state_t           state;
    logic [OFF_W-1:0]         r_off, r_off_next, off_sum;
    logic                     need_two, enough, adv, off_wrap;
    logic [AW-1:0]            idx0, idx1;
    logic [2*BLOCK_W-1:0]     pair;
    logic [LANE_W-1:0]        word;
    logic [LANE_W-1:0]        data_p1;
    logic                     vld_p1, underrun_p1;

    assign avail    = w_cnt_sync - r_cnt;
    assign need_two = r_off > OFF_W'(BLOCK_W - LANE_W);
    assign enough   = need_two ? (avail >= CW'(2)) : (avail >= CW'(1));
    assign adv      = (state == GB_RUN) && enough;

    assign off_sum    = r_off + OFF_W'(LANE_W);
    assign off_wrap   = off_sum >= OFF_W'(BLOCK_W);
    assign r_off_next = !adv ? r_off : (off_wrap ? off_sum - OFF_W'(BLOCK_W) : off_sum);
    assign r_cnt_next = r_cnt + CW'(adv && off_wrap);

    // entry DEPTH-1 pairs with entry 0 through the natural index wrap
    assign idx0 = r_cnt[AW-1:0];
    assign idx1 = idx0 + AW'(1);
    assign pair = {mem[idx1], mem[idx0]};
    assign word = LANE_W'(pair >> r_off);

    // registered output stage
    always_ff @(posedge clk_out or posedge clk_out_reset) begin
        if (clk_out_reset) begin
            state       <= GB_PRIME;
            r_cnt       <= '0;
            r_off       <= '0;
            data_p1     <= '0;
            vld_p1      <= 1'b0;
            underrun_p1 <= 1'b0;
        end else begin
            r_cnt       <= r_cnt_next;
            r_off       <= r_off_next;
            vld_p1      <= adv;
            underrun_p1 <= 1'b0;
            if (adv) begin
                data_p1 <= word;
            end
            if (state == GB_PRIME) begin
                if (avail >= CW'(PRIME)) begin
                    state <= GB_RUN;
                end
            end else if (!enough) begin
                state       <= GB_PRIME;
                underrun_p1 <= 1'b1;
            end
        end
    end

    assign bus.data_out  = data_p1;
    assign bus.valid_out = vld_p1;
    assign bus.underrun  = underrun_p1;

endmodule

// File: tb/tb_tx_async_gearbox.sv
// Scoreboard bench for tx_async_gearbox: input blocks are queued as a bit stream
// and every valid lane word is checked against the next 32 queued bits.
module tb_tx_async_gearbox;

    localparam int DEPTH       = 16;
    localparam int PRIME       = 4;
    localparam int SYNC_STAGES = 2;

    logic clk_in        = 1'b0;
    logic clk_out       = 1'b0;
    logic clk_in_reset  = 1'b0;
    logic clk_out_reset = 1'b0;
    bit   clk_out_run   = 1'b1;

    tx_async_gearbox_if gb();

    tx_async_gearbox #(
        .DEPTH       (DEPTH),
        .PRIME       (PRIME),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_in        (clk_in),
        .clk_in_reset  (clk_in_reset),
        .clk_out       (clk_out),
        .clk_out_reset (clk_out_reset),
        .bus           (gb.slave)
    );

    // clk_in edges land on even times, clk_out rising edges on odd times
    always #3200 clk_in = ~clk_in;

    initial begin
        #1;
        forever begin
            if (clk_out_run) begin
                clk_out = 1'b1;
                #1551;
                clk_out = 1'b0;
                #1553;
            end else begin
                #3104;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit sb[$];
    int word_cnt, underrun_cnt, overflow_cnt, wr_cnt, first_vld_wr;
    bit mon_en = 1'b0;
    logic [31:0] exp_w;

    always @(negedge clk_out) begin
        if (mon_en && !clk_out_reset) begin
            if (gb.underrun) underrun_cnt++;
            if (gb.valid_out) begin
                if (word_cnt == 0) first_vld_wr = wr_cnt;
                n_checks++;
                if (sb.size() < 32) begin
                    n_fail++;
                    $display("FAIL word%0d: data_out=%h but only %0d expected bits queued",
                             word_cnt, gb.data_out, sb.size());
                end else begin
                    for (int i = 0; i < 32; i++) exp_w[i] = sb.pop_front();
                    if (gb.data_out !== exp_w) begin
                        n_fail++;
                        $display("FAIL word%0d: data_out=%h required %h", word_cnt, gb.data_out, exp_w);
                    end
                end
                word_cnt++;
            end
        end
    end

    always @(negedge clk_in) begin
        if (mon_en && !clk_in_reset && gb.overflow) overflow_cnt++;
    end

    task automatic do_reset();
        mon_en = 1'b0;
        gb.valid_in = 1'b0;
        @(negedge clk_in);
        clk_in_reset  = 1'b1;
        clk_out_reset = 1'b1;
        repeat (2) @(negedge clk_in);
        sb.delete();
        word_cnt = 0; underrun_cnt = 0; overflow_cnt = 0; wr_cnt = 0; first_vld_wr = -1;
        clk_in_reset  = 1'b0;
        clk_out_reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_in);
    endtask

    // called at a clk_in negedge; returns at the next one
    task automatic send(input logic [65:0] d, input bit accept);
        n_checks++;
        if (gb.ready !== accept) begin
            n_fail++;
            $display("FAIL ready_before_write%0d: ready=%b required %b", wr_cnt, gb.ready, accept);
        end
        gb.data_in  = d;
        gb.valid_in = 1'b1;
        if (accept) begin
            for (int i = 0; i < 66; i++) sb.push_back(d[i]);
            wr_cnt++;
        end
        @(negedge clk_in);
    endtask

    function automatic logic [65:0] rand_block();
        logic [65:0] d;
        d[31:0]  = $urandom();
        d[63:32] = $urandom();
        d[65:64] = 2'($urandom());
        return d;
    endfunction

    task automatic wait_underrun(input int target, input int budget);
        int n = 0;
        while (underrun_cnt < target && n < budget) begin
            @(negedge clk_out);
            n++;
        end
        n_checks++;
        if (underrun_cnt < target) begin
            n_fail++;
            $display("FAIL underrun_wait: underrun count %0d, required %0d within %0d clk_out",
                     underrun_cnt, target, budget);
        end
        repeat (40) @(negedge clk_out);
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        clk_in_reset  = 1'b1;
        clk_out_reset = 1'b1;
        #50;
        n_checks += 5;
        if (gb.ready !== 1'b0)      begin n_fail++; $display("FAIL rst_ready: %b required 0", gb.ready); end
        if (gb.overflow !== 1'b0)   begin n_fail++; $display("FAIL rst_overflow: %b required 0", gb.overflow); end
        if (gb.data_out !== 32'h0)  begin n_fail++; $display("FAIL rst_data_out: %h required 0", gb.data_out); end
        if (gb.valid_out !== 1'b0)  begin n_fail++; $display("FAIL rst_valid_out: %b required 0", gb.valid_out); end
        if (gb.underrun !== 1'b0)   begin n_fail++; $display("FAIL rst_underrun: %b required 0", gb.underrun); end
        repeat (2) @(negedge clk_in);
        clk_in_reset  = 1'b0;
        clk_out_reset = 1'b0;
        @(negedge clk_in);
        n_checks += 2;
        if (gb.ready !== 1'b1)     begin n_fail++; $display("FAIL post_rst_ready: %b required 1", gb.ready); end
        if (gb.valid_out !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: %b required 0", gb.valid_out); end
    endtask

    task automatic test_nominal();
        logic [65:0] d;
        do_reset();
        for (int k = 0; k < 64; k++) begin
            d = {2'(k), 64'(k)};
            send(d, 1'b1);
        end
        gb.valid_in = 1'b0;
        wait_underrun(1, 2000);
        n_checks += 5;
        if (word_cnt !== 132)   begin n_fail++; $display("FAIL nominal_words: %0d required 132", word_cnt); end
        if (sb.size() !== 0)    begin n_fail++; $display("FAIL nominal_leftover: %0d bits required 0", sb.size()); end
        if (overflow_cnt !== 0) begin n_fail++; $display("FAIL nominal_overflow: %0d required 0", overflow_cnt); end
        if (underrun_cnt !== 1) begin n_fail++; $display("FAIL nominal_underrun: %0d required 1", underrun_cnt); end
        if (first_vld_wr < 4)   begin n_fail++; $display("FAIL nominal_first_valid: after %0d writes required >=4", first_vld_wr); end
    endtask

    task automatic test_priming();
        logic [65:0] d;
        bit found = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) send(rand_block(), 1'b1);
        gb.valid_in = 1'b0;
        repeat (40) @(negedge clk_out);
        n_checks++;
        if (word_cnt !== 0) begin n_fail++; $display("FAIL prime_hold: %0d words required 0", word_cnt); end
        @(negedge clk_in);
        d = rand_block();
        for (int i = 0; i < 66; i++) sb.push_back(d[i]);
        wr_cnt++;
        gb.data_in  = d;
        gb.valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        gb.valid_in = 1'b0;
        for (int i = 0; i < SYNC_STAGES + 2 && !found; i++) begin
            @(posedge clk_out);
            #1;
            if (gb.valid_out === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL prime_latency: valid_out=0 after %0d clk_out, required 1", SYNC_STAGES + 2); end
        wait_underrun(1, 500);
        n_checks += 2;
        if (word_cnt !== 8)  begin n_fail++; $display("FAIL prime_words: %0d required 8", word_cnt); end
        if (sb.size() !== 8) begin n_fail++; $display("FAIL prime_leftover: %0d bits required 8", sb.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        clk_out_run = 1'b0;
        repeat (2) @(negedge clk_in);
        for (int k = 0; k < 16; k++) send(rand_block(), 1'b1);
        send(rand_block(), 1'b0);
        gb.valid_in = 1'b0;
        n_checks++;
        if (gb.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: %b required 1", gb.overflow); end
        @(negedge clk_in);
        n_checks++;
        if (gb.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_end: %b required 0", gb.overflow); end
        clk_out_run = 1'b1;
        wait_underrun(1, 1000);
        @(negedge clk_in);
        n_checks += 4;
        if (word_cnt !== 33)    begin n_fail++; $display("FAIL ovf_words: %0d required 33", word_cnt); end
        if (sb.size() !== 0)    begin n_fail++; $display("FAIL ovf_leftover: %0d bits required 0", sb.size()); end
        if (overflow_cnt !== 1) begin n_fail++; $display("FAIL ovf_count: %0d required 1", overflow_cnt); end
        if (gb.ready !== 1'b1)  begin n_fail++; $display("FAIL ovf_ready_back: %b required 1", gb.ready); end
    endtask

    task automatic test_underrun();
        do_reset();
        for (int k = 0; k < 8; k++) send(rand_block(), 1'b1);
        gb.valid_in = 1'b0;
        wait_underrun(1, 1000);
        n_checks += 4;
        if (word_cnt !== 16)       begin n_fail++; $display("FAIL udr_words: %0d required 16", word_cnt); end
        if (underrun_cnt !== 1)    begin n_fail++; $display("FAIL udr_count: %0d required 1", underrun_cnt); end
        if (gb.valid_out !== 1'b0) begin n_fail++; $display("FAIL udr_valid: %b required 0", gb.valid_out); end
        if (sb.size() !== 16)      begin n_fail++; $display("FAIL udr_held_bits: %0d required 16", sb.size()); end
        @(negedge clk_in);
        for (int k = 0; k < 4; k++) send(rand_block(), 1'b1);
        gb.valid_in = 1'b0;
        wait_underrun(2, 1000);
        n_checks += 3;
        if (word_cnt !== 24)    begin n_fail++; $display("FAIL udr_resume_words: %0d required 24", word_cnt); end
        if (underrun_cnt !== 2) begin n_fail++; $display("FAIL udr_resume_count: %0d required 2", underrun_cnt); end
        if (sb.size() !== 24)   begin n_fail++; $display("FAIL udr_resume_left: %0d bits required 24", sb.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 1000; k++) send(rand_block(), 1'b1);
        gb.valid_in = 1'b0;
        wait_underrun(1, 4000);
        n_checks += 4;
        if (word_cnt !== 2062)  begin n_fail++; $display("FAIL wrap_words: %0d required 2062", word_cnt); end
        if (overflow_cnt !== 0) begin n_fail++; $display("FAIL wrap_overflow: %0d required 0", overflow_cnt); end
        if (underrun_cnt !== 1) begin n_fail++; $display("FAIL wrap_underrun: %0d required 1", underrun_cnt); end
        if (sb.size() !== 16)   begin n_fail++; $display("FAIL wrap_leftover: %0d bits required 16", sb.size()); end
    endtask

    task automatic test_midreset();
        int n = 0;
        do_reset();
        for (int k = 0; k < 10; k++) send(rand_block(), 1'b1);
        gb.valid_in = 1'b0;
        while (word_cnt < 5 && n < 500) begin
            @(negedge clk_out);
            n++;
        end
        n_checks++;
        if (word_cnt < 5) begin n_fail++; $display("FAIL mid_run: %0d words required >=5", word_cnt); end
        #37;
        mon_en = 1'b0;
        clk_in_reset  = 1'b1;
        clk_out_reset = 1'b1;
        #10;
        n_checks += 5;
        if (gb.ready !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_ready: %b required 0", gb.ready); end
        if (gb.overflow !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_overflow: %b required 0", gb.overflow); end
        if (gb.data_out !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data: %h required 0", gb.data_out); end
        if (gb.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: %b required 0", gb.valid_out); end
        if (gb.underrun !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_underrun: %b required 0", gb.underrun); end
        do_reset();
        for (int k = 0; k < 3; k++) send(rand_block(), 1'b1);
        gb.valid_in = 1'b0;
        repeat (40) @(negedge clk_out);
        n_checks++;
        if (word_cnt !== 0) begin n_fail++; $display("FAIL mid_stale: %0d words required 0", word_cnt); end
        @(negedge clk_in);
        for (int k = 0; k < 5; k++) send(rand_block(), 1'b1);
        gb.valid_in = 1'b0;
        wait_underrun(1, 1000);
        n_checks += 2;
        if (word_cnt !== 16)  begin n_fail++; $display("FAIL mid_words: %0d required 16", word_cnt); end
        if (sb.size() !== 16) begin n_fail++; $display("FAIL mid_leftover: %0d bits required 16", sb.size()); end
    endtask

    initial begin
        gb.valid_in = 1'b0;
        gb.data_in  = '0;
        #1000;
        test_reset();
        test_nominal();
        test_priming();
        test_overflow();
        test_underrun();
        test_wrap();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_async_gearbox.md
Name: tx_async_gearbox

Overview:
- Transmit-side counterpart of the PCS receive gearbox.
- Accepts 66-bit encoded blocks at 156.25 MHz (clk_in) and emits a continuous 32-bit stream at 322.265625 MHz (clk_out) toward the SerDes.
- Implemented as a dual-clock block FIFO with a bit-granular read pointer and Gray-coded pointer crossing.
- Flow control on the write side; a prime/run state machine on the read side.

Parameters:
- DEPTH, 16, number of 66-bit entries; power of 2, minimum 4.
- PRIME, 4, entries required before the read side starts or restarts streaming; range 2..DEPTH-2.
- SYNC_STAGES, 2, synchronizer flops per pointer crossing.

Ports:
- clk_in  in  1  block clock, 156.25 MHz
- clk_in_reset  in  1  reset for the clk_in domain
- clk_out  in  1  lane clock, 322.265625 MHz
- clk_out_reset  in  1  asynchronous active-high reset, clk_out domain
- data_in  in  66  encoded block; bit 0 is transmitted first
- valid_in  in  1  data_in valid, clk_in domain
- ready  out  1  FIFO not full, clk_in domain
- overflow  out  1  one-cycle pulse: valid_in while ready=0; that block is dropped
- data_out  out  32  lane word; bit 0 is transmitted first
- valid_out  out  1  data_out valid, clk_out domain
- underrun  out  1  one-cycle pulse: read side ran out of data while in RUN

Behaviour:
- Reset (interface): reset clk_in_reset, asynchronous, active-high; clock clk_in. clk_out_reset is asynchronous active-high on clk_out.
- Both resets must be asserted together. Reset of only one domain is unsupported.
- Reset values: ready=1 after clk_in_reset deasserts (0 while asserted), overflow=0, data_out=0, valid_out=0, underrun=0. All pointers and synchronizers reset to 0. The read state machine resets to PRIME.
- Write side:
  - w_cnt is a binary counter of width log2(DEPTH)+1.
  - Write occurs when valid_in && ready: mem[w_cnt mod DEPTH] <= data_in, then w_cnt++.
  - ready = (w_cnt - r_cnt_sync) < DEPTH. r_cnt_sync is the read-entry count crossed via Gray code, so full is conservative.
  - overflow is registered: it is high the cycle after valid_in && !ready.
  - w_cnt is exported as Gray code from a register (no combinational Gray output).
- Read side position:
  - Position is tracked as r_cnt (entry count, log2(DEPTH)+1 bits) plus r_off (bit offset 0..65). No division is used.
  - avail = w_cnt_sync - r_cnt.
  - need = 1 if r_off <= 34, else 2.
- Read side state machine:
  - PRIME: valid_out=0. Go to RUN when avail >= PRIME.
  - RUN, when avail >= need:
    - Output the 32 bits starting at r_off of the concatenation {mem[r_cnt+1], mem[r_cnt]}.
    - valid_out=1.
    - r_off += 32. If the result is >= 66, subtract 66 and increment r_cnt.
  - RUN, when avail < need: no advance, valid_out=0, pulse underrun, go to PRIME. Pointers are retained; partial-entry bits are not discarded.
- Latency:
  - data_out and valid_out are registered, 1 clk_out after the read decision.
  - Write-to-visible latency is SYNC_STAGES+1 clk_out.
- Rates: 33 output words per 16 input blocks. Nominal clocks are balanced; any ppm offset eventually causes overflow or underrun, and both are reported, not corrected.
- Wrap: r_cnt and w_cnt wrap naturally at 2*DEPTH. Entry DEPTH-1 followed by entry 0 must form a seamless bitstream.

Decomposition:
- pcs_pkg: BLOCK_W=66, LANE_W=32, and a gearbox_state_t enum {PRIME, RUN}.
- Sub-module gray_ptr_sync (parameters WIDTH, STAGES): source-domain bin→Gray register, destination-domain flop chain with reset, then Gray→bin.
- gray_ptr_sync is instantiated twice, once for w_cnt and once for r_cnt.

Test Plan:
- Exact nominal clocks: 64 blocks of counting pattern (block k = {k[1:0], 64-bit k}). The concatenated data_out must reproduce the identical 4224-bit stream, with the first valid_out after ≥4 entries are written.
- Priming: write 3 blocks then stop. valid_out must stay 0. Write a 4th block; valid_out=1 within SYNC_STAGES+2 clk_out.
- Overflow: hold clk_out stopped and write 17 blocks. ready must fall after block 16; block 17 raises a one-cycle overflow and is absent from the later stream.
- Underrun: write 8 blocks (528 bits) then stop. Expect exactly 16 valid words, then one underrun pulse and valid_out=0. Resuming with 4 blocks must output the held 16 bits first.
- Wrap: 1000 blocks at nominal rate. Output must be bit-exact across every DEPTH boundary, with no overflow or underrun.
- Mid-stream reset: assert both resets during RUN. All outputs must reach reset values, then normal priming must occur with no stale data.
